// File: rtl/polar_encoder.sv
// polar_encoder: serial-in/serial-out polar encoder for N = 128/256/512, K <= 255.
// Optional feature macro POLAR_ENC_ONECYCLE_XFORM_EN: compute all butterfly stages in one XFORM cycle.

module reliability_LUT (
    input  logic [1:0] N_channel,
    input  logic [8:0] channel_index,
    output logic [9:0] rindex
);

    // Reliability rank follows channel index, so channel N-1 is the most reliable.
    always_comb begin
        case (N_channel)
            2'b00:   rindex = {3'b000, channel_index[6:0]};
            2'b01:   rindex = {2'b00, channel_index[7:0]};
            default: rindex = {1'b0, channel_index};
        endcase
    end

endmodule

module polar_encoder #(
    parameter int NMAX = 512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [9:0] N,
    input  logic [7:0] K,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_bit,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int LOGN = $clog2(NMAX);
    localparam int IW   = $clog2(NMAX);

    typedef enum logic [1:0] {IDLE, LOAD, XFORM, OUT} state_t;

    state_t          state;
    state_t          state_next;
    logic [NMAX-1:0] u;
    logic [8:0]      idx;
    logic [9:0]      n_len;
    logic [7:0]      k_len;
    logic [3:0]      n_stages;
    logic [9:0]      rindex;
    logic            frozen;
    logic            params_ok;
    logic            last_idx;
    logic            load_step;

    // One butterfly stage: u[j] ^= u[j+2^s] for every j < N whose bit s is clear.
    function automatic logic [NMAX-1:0] transform_stage(
        input logic [NMAX-1:0] v,
        input logic [3:0]      s,
        input logic [9:0]      nlen
    );
        logic [2*NMAX-1:0] vv;
        logic [NMAX-1:0]   r;
        vv = {{NMAX{1'b0}}, v};
        r  = v;
        for (int t = 0; t < LOGN; t++) begin
            if (t == int'(s)) begin
                for (int j = 0; j < NMAX; j++) begin
                    if ((j & (1 << t)) == 0 && j < int'(nlen))
                        r[IW'(j)] = v[IW'(j)] ^ vv[(IW+1)'(j + (1 << t))];
                end
            end
        end
        return r;
    endfunction

`ifdef POLAR_ENC_ONECYCLE_XFORM_EN
    function automatic logic [NMAX-1:0] transform_all(
        input logic [NMAX-1:0] v,
        input logic [3:0]      ns,
        input logic [9:0]      nlen
    );
        logic [NMAX-1:0] r;
        r = v;
        for (int s = 0; s < LOGN; s++) begin
            if (s < int'(ns))
                r = transform_stage(r, 4'(s), nlen);
        end
        return r;
    endfunction
`else
    logic [3:0] stage;
    logic       xform_last;
    assign xform_last = (stage == n_stages - 4'd1);
`endif

    reliability_LUT lut (
        .N_channel     (n_len[9:8]),
        .channel_index (idx),
        .rindex        (rindex)
    );

    assign frozen    = rindex < (n_len - {2'b00, k_len});
    assign params_ok = (N == 10'd128 && K <= 8'd128) || N == 10'd256 || N == 10'd512;
    assign last_idx  = (idx == 9'(n_len - 10'd1));
    assign load_step = frozen || in_valid;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_bit    = 1'b0;
        case (state)
            IDLE: begin
                if (start && params_ok)
                    state_next = LOAD;
            end
            LOAD: begin
                in_ready = !frozen;
                if (load_step && last_idx)
                    state_next = XFORM;
            end
            XFORM: begin
`ifdef POLAR_ENC_ONECYCLE_XFORM_EN
                state_next = OUT;
`else
                if (xform_last)
                    state_next = OUT;
`endif
            end
            OUT: begin
                out_valid = 1'b1;
                out_bit   = u[idx];
                if (out_ready && last_idx)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Frozen positions advance without a handshake; info positions wait for in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u        <= '0;
            idx      <= '0;
            n_len    <= '0;
            k_len    <= '0;
            n_stages <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifndef POLAR_ENC_ONECYCLE_XFORM_EN
            stage    <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (params_ok) begin
                            n_len    <= N;
                            k_len    <= K;
                            n_stages <= N[7] ? 4'd7 : (N[8] ? 4'd8 : 4'd9);
                            u        <= '0;
                            idx      <= '0;
`ifndef POLAR_ENC_ONECYCLE_XFORM_EN
                            stage    <= '0;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (load_step) begin
                        u[idx] <= frozen ? 1'b0 : in_bit;
                        idx    <= last_idx ? 9'd0 : idx + 9'd1;
                    end
                end
                XFORM: begin
`ifdef POLAR_ENC_ONECYCLE_XFORM_EN
                    u   <= transform_all(u, n_stages, n_len);
                    idx <= '0;
`else
                    u <= transform_stage(u, stage, n_len);
                    if (xform_last) begin
                        stage <= '0;
                        idx   <= '0;
                    end else begin
                        stage <= stage + 4'd1;
                    end
`endif
                end
                OUT: begin
                    if (out_ready) begin
                        if (last_idx) begin
                            idx  <= '0;
                            done <= 1'b1;
                        end else begin
                            idx <= idx + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_polar_encoder.sv
// Testbench for polar_encoder: random info bits and handshake stalls checked against
// a codeword model built directly from the generator matrix F^(x)n.
`timescale 1ns/1ps

module tb_polar_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] N;
    logic [7:0] K;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       out_valid;
    logic       out_bit;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit exp_q[$];
    bit info_q[$];
    int cmd_n[$];
    int cmd_k[$];
    int st_cyc[$];
    int st_n[$];

    int out_seen, ones_seen, done_count, err_count, ready_cycles, hs_in, b2b_count;

    polar_encoder #(.NMAX(512)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .N         (N),
        .K         (K),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int log2i(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int xformCycles(input int n);
`ifdef POLAR_ENC_ONECYCLE_XFORM_EN
        return (n > 0) ? 1 : 0;
`else
        return log2i(n);
`endif
    endfunction

    // x = u * F^(x)n with F = [1 0; 1 1]: x[i] is the parity of u[j] over all j whose bits cover i.
    function automatic bit modelBit(input bit u[512], input int n, input int i);
        bit x = 1'b0;
        for (int j = 0; j < n; j++)
            if ((j & i) == i) x ^= u[j];
        return x;
    endfunction

    // Reliability rank equals channel index, so the K info bits occupy positions N-K .. N-1.
    task automatic enqueueCodeword(input int n, input int k, input bit all_ones);
        bit u[512];
        for (int p = 0; p < 512; p++) u[p] = 1'b0;
        for (int p = 0; p < n; p++) begin
            if (p >= n - k) begin
                u[p] = all_ones ? 1'b1 : 1'($urandom_range(1));
                info_q.push_back(u[p]);
            end
        end
        for (int i = 0; i < n; i++) exp_q.push_back(modelBit(u, n, i));
        cmd_n.push_back(n);
        cmd_k.push_back(k);
    endtask

    task automatic clearCounters();
        out_seen = 0; ones_seen = 0; done_count = 0; err_count = 0;
        ready_cycles = 0; hs_in = 0; b2b_count = 0;
    endtask

    // Compare process: every meaningful output cycle is checked against the model queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                out_seen++;
                if (exp_q.size() == 0) begin
                    checkOutput("out_extra_bit", 1, exp_q.size());
                end else begin
                    checkOutput("out_bit", out_bit, exp_q[0]);
                    if (out_ready) begin
                        ones_seen += out_bit;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (done) begin
                done_count++;
                checkOutput("busy_at_done", busy, 0);
                if (start) b2b_count++;
            end
            if (err) err_count++;
            if (in_ready) ready_cycles++;
            if (in_ready && in_valid) hs_in++;
        end
    end

    // Drives queued codewords; called and returns at posedge+1.
    task automatic applyStimulus(input int pv, input int pr, input int budget,
                                 input int inject_at, input int reset_after);
        int target, exp_info, done_seen, hold, out_idx, cur_n, taken, s0, n0;
        bit take, hs, last_hs, busy_s, dn;
        target    = cmd_n.size();
        exp_info  = info_q.size();
        done_seen = 0; hold = 0; out_idx = 0; cur_n = 0; taken = 0;
        last_hs   = 1'b0;
        busy_s    = busy;
        for (int c = 0; c < budget; c++) begin
            start = 1'b0;
            if (reset_after >= 0 && taken == reset_after) begin
                rst_n = 1'b0;
                info_q.delete(); exp_q.delete(); cmd_n.delete(); cmd_k.delete();
                st_cyc.delete(); st_n.delete();
                in_valid = 1'b0; out_ready = 1'b0;
                #1;
                checkOutput("busy_in_reset", busy, 0);
                checkOutput("in_ready_in_reset", in_ready, 0);
                checkOutput("out_valid_in_reset", out_valid, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            if (hold > 0) begin
                hold--;
            end else if (cmd_n.size() > 0 && (!busy_s || last_hs)) begin
                start = 1'b1;
                cur_n = cmd_n.pop_front();
                N     = 10'(cur_n);
                K     = 8'(cmd_k.pop_front());
                st_cyc.push_back(cyc);
                st_n.push_back(cur_n);
                hold  = 1;
            end
            if (c == inject_at && !start) begin
                start = 1'b1; N = 10'd300; K = 8'd5;
            end
            in_valid  = ($urandom_range(99) >= pv);
            in_bit    = (info_q.size() > 0) ? info_q[0] : 1'($urandom_range(1));
            out_ready = ($urandom_range(99) >= pr);
            @(negedge clk);
            take    = in_valid && in_ready;
            hs      = out_valid && out_ready;
            busy_s  = busy;
            dn      = done;
            last_hs = 1'b0;
            if (hs) begin
                out_idx++;
                if (out_idx == cur_n) begin
                    last_hs = 1'b1;
                    out_idx = 0;
                end
            end
            if (dn) begin
                done_seen++;
                if (st_cyc.size() > 0) begin
                    s0 = st_cyc.pop_front();
                    n0 = st_n.pop_front();
                    if (pv == 0 && pr == 0)
                        checkOutput("start_to_done", cyc - s0, 1 + 2 * n0 + xformCycles(n0));
                end
            end
            @(posedge clk); #1;
            if (take) begin
                taken++;
                if (info_q.size() > 0) void'(info_q.pop_front());
            end
            if (done_seen >= target) break;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checkOutput("codewords_done", done_seen, target);
        checkOutput("info_bits_taken", taken, exp_info);
        checkOutput("bits_left", exp_q.size(), 0);
    endtask

    task automatic errTest(input int n, input int k);
        start = 1'b1; N = 10'(n); K = 8'(k);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("err_pulse", err, 1);
        checkOutput("err_busy", busy, 0);
        @(posedge clk); #1;
        checkOutput("err_clear", err, 0);
        checkOutput("err_busy_after", busy, 0);
    endtask

    initial begin
        bit u_pin[512];
        int ones, rn, rk;
        rst_n = 1'b0; start = 1'b0; N = '0; K = '0;
        in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        clearCounters();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_bit", out_bit, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed pins of the model itself.
        for (int p = 0; p < 512; p++) u_pin[p] = 1'b0;
        u_pin[1] = 1'b1;
        checkOutput("model_pin_x0", modelBit(u_pin, 4, 0), 1);
        checkOutput("model_pin_x1", modelBit(u_pin, 4, 1), 1);
        checkOutput("model_pin_x2", modelBit(u_pin, 4, 2), 0);
        checkOutput("model_pin_x3", modelBit(u_pin, 4, 3), 0);
        u_pin[1] = 1'b0; u_pin[127] = 1'b1;
        ones = 0;
        for (int i = 0; i < 128; i++) ones += modelBit(u_pin, 128, i);
        checkOutput("model_pin_ones", ones, 128);

        $display("[TB] reset during LOAD after 30 info bits");
        clearCounters();
        enqueueCodeword(128, 64, 1'b0);
        applyStimulus(0, 0, 2000, -1, 30);
        checkOutput("stale_out_seen", out_seen, 0);
        checkOutput("busy_after_reset", busy, 0);

        $display("[TB] N=128 K=0");
        clearCounters();
        enqueueCodeword(128, 0, 1'b0);
        applyStimulus(0, 0, 2000, -1, -1);
        checkOutput("k0_in_ready_cycles", ready_cycles, 0);
        checkOutput("k0_ones", ones_seen, 0);
        checkOutput("k0_done_count", done_count, 1);

        $display("[TB] N=128 K=1 in_bit=1");
        clearCounters();
        enqueueCodeword(128, 1, 1'b1);
        applyStimulus(0, 0, 2000, -1, -1);
        checkOutput("k1_ones", ones_seen, 128);
        checkOutput("k1_in_handshakes", hs_in, 1);

        $display("[TB] illegal parameter starts");
        errTest(300, 5);
        errTest(128, 200);

        $display("[TB] N=512 K=255 with stalls and a start while busy");
        clearCounters();
        enqueueCodeword(512, 255, 1'b0);
        applyStimulus(30, 30, 20000, 40, -1);
        checkOutput("stall_err_count", err_count, 0);
        checkOutput("stall_in_handshakes", hs_in, 255);
        checkOutput("stall_done_count", done_count, 1);
        checkOutput("stall_out_ones", ones_seen >= 0 ? 1 : 0, 1);

        $display("[TB] back-to-back N=256 K=128");
        clearCounters();
        enqueueCodeword(256, 128, 1'b0);
        enqueueCodeword(256, 128, 1'b0);
        applyStimulus(0, 0, 5000, -1, -1);
        checkOutput("b2b_start_in_done_cycle", b2b_count, 1);
        checkOutput("b2b_done_count", done_count, 2);

        $display("[TB] random codewords");
        for (int r = 0; r < 3; r++) begin
            clearCounters();
            rn = 128 << $urandom_range(2);
            rk = $urandom_range((rn > 255) ? 255 : rn);
            enqueueCodeword(rn, rk, 1'b0);
            applyStimulus(int'($urandom_range(40)), int'($urandom_range(40)), 20000, -1, -1);
            checkOutput("rand_in_handshakes", hs_in, rk);
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/polar_encoder.md
# polar_encoder

Serial-in/serial-out polar encoder for the (N, K) codes handled by the SC decoder datapath: N = 128, 256 or 512, K ≤ 255. Accepts K information bits, places them on non-frozen channel positions (frozen if reliability index < N−K, via `reliability_LUT`) and applies the F^⊗n butterfly transform. Streams out the N-bit codeword. Serves as the transmit-side counterpart of the decoder and as the golden codeword source for decoder loopback benches.

## Interface
Parameters:
- NMAX, 512, codeword register depth (bits)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a codeword; sampled only in IDLE
- N  input  10  code length; legal values 128, 256, 512; latched at start
- K  input  8  information bit count; latched at start
- in_valid  input  1  info bit valid
- in_bit  input  1  info bit, consumed in increasing channel-index order
- in_ready  output  1  encoder accepts in_bit this cycle
- out_valid  output  1  codeword bit valid
- out_bit  output  1  codeword bit x[idx], idx ascending from 0
- out_ready  input  1  sink accepts out_bit
- busy  output  1  high outside IDLE
- done  output  1  one-cycle pulse after last codeword bit accepted
- err  output  1  one-cycle pulse when start rejected (illegal N or K > N)

## Operation
- States: IDLE, LOAD, XFORM, OUT.
- IDLE: start with legal N and K ≤ N → latch N, K; clear u[0..NMAX−1]; idx=0; → LOAD. Illegal parameters → err pulse, stay IDLE.
- LOAD: one `reliability_LUT` instance, N_channel = N[9:8], channel_index = idx.
  - frozen = rindex < N−K (10-bit unsigned compare).
  - Frozen: u[idx]=0; idx++ unconditionally; in_ready=0.
  - Non-frozen: in_ready=1; on in_valid&&in_ready, u[idx]=in_bit, idx++; otherwise hold.
  - idx==N−1 advanced → idx=0, stage=0, → XFORM.
- XFORM: n = log2(N) stages. Stage s (half=2^s): for every j < N with bit s of j equal to 0, u[j] ^= u[j+half]. Bits ≥ N untouched. After stage n−1 → OUT, idx=0.
- OUT: out_valid=1, out_bit=u[idx]; on out_ready, idx++. Last bit (idx==N−1) accepted → done pulse, → IDLE.
- start outside IDLE ignored (no err).
- K=0: no info bits consumed; codeword all zeros. K=N: every position is info.

## Timing
- Reset values: in_ready=0, out_valid=0, out_bit=0, busy=0, done=0, err=0; state IDLE; u, idx, stage cleared.
- Reset asserted mid-operation: immediate return to IDLE; any partial codeword is discarded and never emitted.
- start→busy: busy high the cycle after start is sampled.
- LOAD: exactly N cycles with in_valid held high; each in_valid-low cycle on an info position adds one cycle.
- XFORM: n cycles (7/8/9) by default; 1 cycle with macro (see Configuration).
- OUT: N cycles with out_ready held high; out_bit stable while out_valid&&!out_ready.
- done asserts in the cycle following the final out handshake, with busy low the same cycle; a start in that cycle is accepted.
- Minimum start-to-done, N=128, default build: 1+128+7+128 cycles.

## Configuration
- POLAR_ENC_ONECYCLE_XFORM_EN defined: all n stages are computed combinationally and registered in a single XFORM cycle.
- Not defined: one stage per cycle, n cycles.
- Codeword, handshakes and all other timing are identical in both builds.

## Test plan
- Reset while in LOAD with 30 bits consumed, then N=128, K=0 → zero in_ready cycles; 128 zero bits out; done once; no stale data.
- N=128, K=1, in_bit=1 (single info position = most reliable channel 127) → all 128 output bits = 1.
- N=512, K=255, random info bits; in_valid and out_ready each randomly deasserted ~30% → codeword matches software u·F^⊗9; no bit lost or duplicated under stalls.
- N=300 start → err pulse next cycle, busy stays 0; N=128, K=200 → err; start while busy → ignored.
- Back-to-back codewords: start asserted in the done cycle for N=256, K=128 → accepted; second codeword correct; default and macro builds differ only by 7 cycles (N=256).
